// File: rtl/pmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmc_pkg
// Description : Shared types and constants for the PMC shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pmc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } pmc_seq_state_t;

    localparam int PMC_WORD_BITS  = 16;
    localparam int PMC_MIN_PERIOD = 2;

endpackage
`default_nettype wire

// File: rtl/pmc_period_timer.sv
`default_nettype none
// ============================================================================
// Module      : pmc_period_timer
// Description : Loadable, auto-reloading down-counter marking the first and
//               last clk cycle of each bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module pmc_period_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic [DIV_W-1:0] reload_val,
    output logic             period_start,
    output logic             period_last
);

    logic [DIV_W-1:0] cnt;

    // Reloading on zero keeps periods back-to-back without FSM involvement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt == '0) begin
            cnt <= reload_val;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign period_start = (cnt == reload_val);
    assign period_last  = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/pmc_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pmc_shift_sequencer
// Description : sh/pclk strobe sequencer for the pixel-matrix shift-out path.
//               Optional abort support: PMC_SHIFT_SEQUENCER_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pmc_shift_sequencer
    import pmc_pkg::*;
#(
    parameter int WORD_BITS = PMC_WORD_BITS,
    parameter int DIV_W     = 8,
    parameter int WORDS_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
    input  logic                         abort,
    output logic                         aborted,
`endif
    input  logic [DIV_W-1:0]             cfg_div,
    input  logic [WORDS_W-1:0]           cfg_words,
    output logic                         sh,
    output logic                         pclk,
    output logic [$clog2(WORD_BITS)-1:0] bit_cnt,
    output logic [WORDS_W-1:0]           word_cnt,
    output logic                         busy,
    output logic                         done
);

    localparam int                BIT_W    = $clog2(WORD_BITS);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_BITS - 1);
    localparam logic [DIV_W-1:0]  MIN_DIV  = DIV_W'(PMC_MIN_PERIOD - 1);

    pmc_seq_state_t     state;
    logic [DIV_W-1:0]   div_lat;
    logic [WORDS_W-1:0] words_lat;
    logic [DIV_W-1:0]   div_eff;
    logic [DIV_W-1:0]   tmr_load_val;
    logic               start_ok;
    logic               abort_take;
    logic               tmr_load;
    logic               period_start;
    logic               period_last;

    assign start_ok     = (state == IDLE) && start;
    assign div_eff      = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
    assign tmr_load     = start_ok || abort_take;
    assign tmr_load_val = start_ok ? div_eff : div_lat;

`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
    logic abort_seen;
    assign abort_take = abort && ((state == SETUP) || (state == SHIFT));
`else
    assign abort_take = 1'b0;
`endif

    pmc_period_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load         (tmr_load),
        .load_val     (tmr_load_val),
        .reload_val   (div_lat),
        .period_start (period_start),
        .period_last  (period_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_lat   <= '0;
            words_lat <= '0;
            sh        <= 1'b0;
            pclk      <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
            aborted    <= 1'b0;
            abort_seen <= 1'b0;
`endif
        end else begin
            pclk <= 1'b0;
            done <= 1'b0;
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
            aborted <= 1'b0;
            if (abort_take) begin
                abort_seen <= 1'b1;
            end
`endif
            // A strobe cycle is always counted, even when an abort lands on it.
            if ((state == SHIFT) && period_start) begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    word_cnt <= word_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        div_lat   <= div_eff;
                        words_lat <= cfg_words;
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
                        abort_seen <= 1'b0;
`endif
                        if (cfg_words != '0) begin
                            state <= SETUP;
                            sh    <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (abort_take) begin
                        state <= HOLD;
                    end else if (period_last) begin
                        state <= SHIFT;
                        pclk  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort_take) begin
                        state <= HOLD;
                    end else if (period_last) begin
                        if ((word_cnt == words_lat) && (bit_cnt == '0)) begin
                            state <= HOLD;
                        end else begin
                            pclk <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (period_last) begin
                        state   <= DONE;
                        sh      <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bit_cnt <= '0;
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
                        aborted <= abort_seen;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmc_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmc_shift_sequencer
// Description : Self-checking bench for pmc_shift_sequencer against a
//               timeline model built from the period/word arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmc_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_div;
    logic [15:0] cfg_words;
    logic        sh;
    logic        pclk;
    logic [3:0]  bit_cnt;
    logic [15:0] word_cnt;
    logic        busy;
    logic        done;
    logic        aborted;
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
    logic        abort;
`endif

    int tests = 0;
    int fails = 0;

    // Packed sample: {aborted, done, busy, sh, pclk, bit_cnt, word_cnt}
    logic [24:0] cap [0:1023];

    always #5 clk = ~clk;

    pmc_shift_sequencer #(
        .WORD_BITS(16),
        .DIV_W    (8),
        .WORDS_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .cfg_div   (cfg_div),
        .cfg_words (cfg_words),
        .sh        (sh),
        .pclk      (pclk),
        .bit_cnt   (bit_cnt),
        .word_cnt  (word_cnt),
        .busy      (busy),
        .done      (done)
    );

`ifndef PMC_SHIFT_SEQUENCER_ABORT_EN
    assign aborted = 1'b0;
`endif

    function automatic int period_of(input int div);
        return ((div < 1) ? 1 : div) + 1;
    endfunction

    // Cycle t=1 is the first cycle after the edge that accepted start.
    // Strobes fall at P+1+kP; an abort at cycle ab keeps strobes up to ab
    // and ends sh at ab+P.
    function automatic logic [24:0] exp_at(input int t, input int p, input int w, input int ab);
        int end_sh, n, ntot, s, bitv, wordv;
        logic shv, pc, dn, abv;
        if (w == 0)       end_sh = 0;
        else if (ab >= 0) end_sh = ab + p;
        else              end_sh = 2 * p + 16 * w * p;
        n = 0; ntot = 0; pc = 1'b0;
        for (int k = 0; k < 16 * w; k++) begin
            s = p + 1 + k * p;
            if (ab >= 0 && s > ab) break;
            ntot++;
            if (s < t) n++;
            if (s == t) pc = 1'b1;
        end
        shv = (t >= 1) && (t <= end_sh);
        if (shv) begin
            bitv = n % 16; wordv = n / 16;
        end else begin
            bitv = 0; wordv = ntot / 16;
        end
        dn  = (t == end_sh + 1);
        abv = dn && (ab >= 0) && (w != 0);
        return {abv, dn, shv, shv, pc, 4'(bitv), 16'(wordv)};
    endfunction

    // Caller sits at a negedge. poke>0 re-pulses start and rewrites cfg_div
    // at that cycle; ab>0 raises abort in that cycle.
    task automatic run_capture(input int div, input int words, input int ncyc,
                               input int poke, input int ab);
        cfg_div   = 8'(div);
        cfg_words = 16'(words);
        start     = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            start  = 1'b0;
            cap[i] = {aborted, done, busy, sh, pclk, bit_cnt, word_cnt};
            if (i == poke) begin
                start     = 1'b1;
                cfg_div   = 8'd7;
                cfg_words = 16'($urandom_range(1, 9));
            end
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
            abort = (i == ab);
`endif
        end
        start = 1'b0;
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic test_reset;
        logic [24:0] obs;
        rst = 1'b1; start = 1'b1; cfg_div = 8'd3; cfg_words = 16'd1;
        repeat (3) @(negedge clk);
        obs = {aborted, done, busy, sh, pclk, bit_cnt, word_cnt};
        tests++;
        if (obs !== 25'd0) begin
            fails++; $display("FAIL reset_state got %h exp %h", obs, 25'd0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        obs = {aborted, done, busy, sh, pclk, bit_cnt, word_cnt};
        tests++;
        if (obs !== 25'd0) begin
            fails++; $display("FAIL reset_idle got %h exp %h", obs, 25'd0);
        end
    endtask

    task automatic test_basic;
        int n_sh, n_pc, done_at;
        logic [24:0] e;
        run_capture(3, 1, 80, -1, -1);
        n_sh = 0; n_pc = 0; done_at = -1;
        for (int i = 1; i <= 80; i++) begin
            e = exp_at(i, 4, 1, -1);
            tests++;
            if (cap[i] !== e) begin
                fails++; $display("FAIL basic cyc %0d got %h exp %h", i, cap[i], e);
            end
            n_sh += int'(cap[i][21]);
            n_pc += int'(cap[i][20]);
            if (cap[i][23] && done_at < 0) done_at = i;
        end
        tests++;
        if (n_sh != 72) begin fails++; $display("FAIL basic_sh_cycles got %0d exp 72", n_sh); end
        tests++;
        if (n_pc != 16) begin fails++; $display("FAIL basic_pclk_count got %0d exp 16", n_pc); end
        // cycle 74 when the start cycle itself is counted as cycle 1
        tests++;
        if (done_at + 1 != 74) begin fails++; $display("FAIL basic_done_cycle got %0d exp 74", done_at + 1); end
        tests++;
        if (cap[80][15:0] !== 16'd1) begin fails++; $display("FAIL basic_word_cnt got %0d exp 1", cap[80][15:0]); end
    endtask

    task automatic test_fast;
        int n_pc, wraps;
        logic [24:0] e;
        run_capture(0, 2, 72, -1, -1);
        n_pc = 0; wraps = 0;
        for (int i = 1; i <= 72; i++) begin
            e = exp_at(i, 2, 2, -1);
            tests++;
            if (cap[i] !== e) begin
                fails++; $display("FAIL fast cyc %0d got %h exp %h", i, cap[i], e);
            end
            n_pc += int'(cap[i][20]);
            if (i > 1 && cap[i-1][19:16] == 4'd15 && cap[i][19:16] == 4'd0 && cap[i][15:0] == 16'd1)
                wraps++;
        end
        tests++;
        if (n_pc != 32) begin fails++; $display("FAIL fast_pclk_count got %0d exp 32", n_pc); end
        tests++;
        if (wraps != 1) begin fails++; $display("FAIL fast_mid_wrap got %0d exp 1", wraps); end
        tests++;
        if (cap[72][15:0] !== 16'd2) begin fails++; $display("FAIL fast_word_cnt got %0d exp 2", cap[72][15:0]); end
    endtask

    task automatic test_zero_words;
        logic [24:0] e;
        run_capture(5, 0, 6, -1, -1);
        for (int i = 1; i <= 6; i++) begin
            e = exp_at(i, 6, 0, -1);
            tests++;
            if (cap[i] !== e) begin
                fails++; $display("FAIL zero_words cyc %0d got %h exp %h", i, cap[i], e);
            end
        end
        tests++;
        if (cap[1][23] !== 1'b1) begin fails++; $display("FAIL zero_done got %b exp 1", cap[1][23]); end
    endtask

    task automatic test_ignore_changes;
        int last_pc, bad_gap;
        logic [24:0] e;
        run_capture(3, 2, 144, 30, -1);
        last_pc = -1; bad_gap = 0;
        for (int i = 1; i <= 144; i++) begin
            e = exp_at(i, 4, 2, -1);
            tests++;
            if (cap[i] !== e) begin
                fails++; $display("FAIL ignore cyc %0d got %h exp %h", i, cap[i], e);
            end
            if (cap[i][20]) begin
                if (last_pc >= 0 && i - last_pc != 4) bad_gap++;
                last_pc = i;
            end
        end
        tests++;
        if (bad_gap != 0) begin fails++; $display("FAIL ignore_spacing got %0d bad gaps exp 0", bad_gap); end
    endtask

    task automatic test_reset_mid;
        logic [24:0] obs, e;
        cfg_div = 8'd3; cfg_words = 16'd1; start = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        obs = {aborted, done, busy, sh, pclk, bit_cnt, word_cnt};
        tests++;
        if (obs[19:16] !== 4'd5) begin fails++; $display("FAIL midrst_pre bit_cnt got %0d exp 5", obs[19:16]); end
        rst = 1'b1;
        @(negedge clk);
        obs = {aborted, done, busy, sh, pclk, bit_cnt, word_cnt};
        tests++;
        if (obs !== 25'd0) begin fails++; $display("FAIL midrst_clear got %h exp %h", obs, 25'd0); end
        rst = 1'b0;
        @(negedge clk);
        run_capture(3, 1, 76, -1, -1);
        for (int i = 1; i <= 76; i++) begin
            e = exp_at(i, 4, 1, -1);
            tests++;
            if (cap[i] !== e) begin
                fails++; $display("FAIL midrst_rerun cyc %0d got %h exp %h", i, cap[i], e);
            end
        end
    endtask

    task automatic test_random;
        int div, w, p, n;
        logic [24:0] e;
        for (int r = 0; r < 6; r++) begin
            div = $urandom_range(0, 9);
            w   = $urandom_range(1, 3);
            p   = period_of(div);
            n   = 2 * p + 16 * w * p + 4;
            run_capture(div, w, n, -1, -1);
            for (int i = 1; i <= n; i++) begin
                e = exp_at(i, p, w, -1);
                tests++;
                if (cap[i] !== e) begin
                    fails++;
                    $display("FAIL random div=%0d words=%0d cyc %0d got %h exp %h", div, w, i, cap[i], e);
                end
            end
        end
    endtask

`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
    task automatic test_abort;
        int div, w, p, n, ab;
        logic [24:0] e;
        // Abort in the low cycle right after the 20th strobe (cycle 20P+1).
        ab = 20 * 4 + 2;
        n  = ab + 4 + 4;
        run_capture(3, 3, n, -1, ab);
        for (int i = 1; i <= n; i++) begin
            e = exp_at(i, 4, 3, ab);
            tests++;
            if (cap[i] !== e) begin
                fails++; $display("FAIL abort cyc %0d got %h exp %h", i, cap[i], e);
            end
        end
        tests++;
        if (cap[ab + 5][24:23] !== 2'b11 || cap[ab + 5][15:0] !== 16'd1) begin
            fails++; $display("FAIL abort_final got %h exp aborted+done word 1", cap[ab + 5]);
        end
        for (int r = 0; r < 4; r++) begin
            div = $urandom_range(0, 6);
            w   = $urandom_range(1, 3);
            p   = period_of(div);
            ab  = $urandom_range(1, p + 16 * w * p - 1);
            n   = ab + p + 4;
            run_capture(div, w, n, -1, ab);
            for (int i = 1; i <= n; i++) begin
                e = exp_at(i, p, w, ab);
                tests++;
                if (cap[i] !== e) begin
                    fails++;
                    $display("FAIL abort_rand div=%0d words=%0d ab=%0d cyc %0d got %h exp %h", div, w, ab, i, cap[i], e);
                end
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; cfg_div = 8'd0; cfg_words = 16'd0;
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
        abort = 1'b0;
`endif
        @(negedge clk);
        test_reset;
        test_basic;
        test_fast;
        test_zero_words;
        test_ignore_changes;
        test_reset_mid;
        test_random;
`ifdef PMC_SHIFT_SEQUENCER_ABORT_EN
        test_abort;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
